// File: rtl/bht_btb_predictor_pkg.sv
`default_nettype none
// ============================================================================
// bht_btb_predictor_pkg : shared modes, counter ops and counter init helpers
// Rev 1.0
// ============================================================================
package bht_btb_predictor_pkg;

    localparam int BP_MODE_BIMODAL = 0;
    localparam int BP_MODE_GSHARE  = 1;

    typedef enum logic [2:0] {
        CTR_HOLD    = 3'd0,
        CTR_INC     = 3'd1,
        CTR_DEC     = 3'd2,
        CTR_SET_MAX = 3'd3,
        CTR_SET_VAL = 3'd4
    } ctr_op_e;

    function automatic int unsigned ctr_weak_nt(input int unsigned bits);
        return (32'd1 << (bits - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned ctr_weak_t(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

    function automatic int unsigned ctr_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_btb_predictor_if.sv
`default_nettype none
// ============================================================================
// bht_btb_predictor_if : IF-stage lookup and EX-stage resolution bundle
// Rev 1.0
// ============================================================================
interface bht_btb_predictor_if #(
    parameter int ADDR_SIZE = 32,
    parameter int IDX       = 6
);
    logic [ADDR_SIZE-1:0] if_pc;
    logic [ADDR_SIZE-1:0] if_pcplus4;
    logic                 pred_taken;
    logic [ADDR_SIZE-1:0] pred_target;
    logic [IDX-1:0]       pred_idx;
    logic                 ex_valid;
    logic [ADDR_SIZE-1:0] ex_pc;
    logic [IDX-1:0]       ex_idx;
    logic                 ex_is_jump;
    logic                 ex_taken;
    logic [ADDR_SIZE-1:0] ex_target;
    logic                 flush_tbl;

    modport master (
        output if_pc, if_pcplus4, ex_valid, ex_pc, ex_idx, ex_is_jump,
               ex_taken, ex_target, flush_tbl,
        input  pred_taken, pred_target, pred_idx
    );

    modport slave (
        input  if_pc, if_pcplus4, ex_valid, ex_pc, ex_idx, ex_is_jump,
               ex_taken, ex_target, flush_tbl,
        output pred_taken, pred_target, pred_idx
    );
endinterface
`default_nettype wire

// File: rtl/bht_btb_predictor_sat_ctr.sv
`default_nettype none
// ============================================================================
// sat_ctr : combinational next-value logic for a saturating counter
// Rev 1.0
// ============================================================================
module sat_ctr
    import bht_btb_predictor_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  ctr_op_e             op_i,
    input  logic [CTR_BITS-1:0] cur_i,
    input  logic [CTR_BITS-1:0] val_i,
    output logic [CTR_BITS-1:0] nxt_o
);
    localparam logic [CTR_BITS-1:0] c_CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));

    always_comb begin
        nxt_o = cur_i;
        case (op_i)
            CTR_INC:     if (cur_i != c_CTR_MAX) nxt_o = cur_i + 1'b1;
            CTR_DEC:     if (cur_i != '0)        nxt_o = cur_i - 1'b1;
            CTR_SET_MAX: nxt_o = c_CTR_MAX;
            CTR_SET_VAL: nxt_o = val_i;
            default:     nxt_o = cur_i;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/bht_btb_predictor.sv
`default_nettype none
// ============================================================================
// bht_btb_predictor : direct-mapped BHT/BTB, bimodal or gshare indexed
// Rev 1.0
// ============================================================================
module bht_btb_predictor
    import bht_btb_predictor_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int ENTRIES   = 64,
    parameter int TAG_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int GHR_BITS  = 6,
    parameter int MODE      = BP_MODE_BIMODAL
) (
    input  logic                  clk,
    input  logic                  reset,
    bht_btb_predictor_if.slave    bp
);
    localparam int IDX    = $clog2(ENTRIES);
    localparam int TAG_LO = IDX + 2;
    localparam logic [CTR_BITS-1:0] c_WEAK_NT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] c_WEAK_T  = CTR_BITS'(ctr_weak_t(CTR_BITS));

    logic                 valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];
    logic [ADDR_SIZE-1:0] target_q [ENTRIES];
    logic [GHR_BITS-1:0]  ghr_q;

    logic [IDX-1:0]       w_ghr_ext;
    logic [IDX-1:0]       w_lkp_idx;
    logic [TAG_BITS-1:0]  w_lkp_tag;
    logic                 w_lkp_hit;
    logic [TAG_BITS-1:0]  w_ex_tag;
    logic                 w_ex_hit;
    logic                 w_upd;
    ctr_op_e              w_ctr_op;
    logic                 w_wr_ctr;
    logic                 w_wr_tgt;
    logic                 w_alloc;
    logic [CTR_BITS-1:0]  ctr_d;
    logic                 w_unused_pc;

    assign w_unused_pc = ^{bp.if_pc[1:0], bp.ex_pc[1:0]};

    // History only exists in gshare mode; bimodal sees a constant zero.
    generate
        if (MODE == BP_MODE_GSHARE) begin : g_gshare
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ghr_q <= '0;
                end else if (w_upd && !bp.ex_is_jump) begin
                    ghr_q <= GHR_BITS'({ghr_q, bp.ex_taken});
                end
            end
        end else begin : g_bimodal
            assign ghr_q = '0;
        end
    endgenerate

    assign w_ghr_ext = IDX'(ghr_q);
    assign w_lkp_idx = bp.if_pc[IDX+1:2] ^ w_ghr_ext;
    assign w_lkp_tag = bp.if_pc[TAG_LO+TAG_BITS-1:TAG_LO];
    assign w_lkp_hit = valid_q[w_lkp_idx] && (tag_q[w_lkp_idx] == w_lkp_tag);

    assign bp.pred_idx    = w_lkp_idx;
    assign bp.pred_taken  = w_lkp_hit && ctr_q[w_lkp_idx][CTR_BITS-1];
    assign bp.pred_target = bp.pred_taken ? target_q[w_lkp_idx] : bp.if_pcplus4;

    // Update uses the index carried from IF so it matches the lookup history.
    assign w_ex_tag = bp.ex_pc[TAG_LO+TAG_BITS-1:TAG_LO];
    assign w_ex_hit = valid_q[bp.ex_idx] && (tag_q[bp.ex_idx] == w_ex_tag);
    assign w_upd    = bp.ex_valid && !bp.flush_tbl;

    always_comb begin
        w_ctr_op = CTR_HOLD;
        w_wr_ctr = 1'b0;
        w_wr_tgt = 1'b0;
        w_alloc  = 1'b0;
        if (w_upd) begin
            if (w_ex_hit) begin
                w_wr_ctr = 1'b1;
                if (bp.ex_is_jump) begin
                    w_ctr_op = CTR_SET_MAX;
                    w_wr_tgt = 1'b1;
                end else begin
                    w_ctr_op = bp.ex_taken ? CTR_INC : CTR_DEC;
                    w_wr_tgt = bp.ex_taken;
                end
            end else if (bp.ex_taken) begin
                w_alloc  = 1'b1;
                w_wr_ctr = 1'b1;
                w_wr_tgt = 1'b1;
                w_ctr_op = bp.ex_is_jump ? CTR_SET_MAX : CTR_SET_VAL;
            end
        end
    end

    sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .op_i  (w_ctr_op),
        .cur_i (ctr_q[bp.ex_idx]),
        .val_i (c_WEAK_T),
        .nxt_o (ctr_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= c_WEAK_NT;
            end
        end else if (bp.flush_tbl) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (w_wr_ctr) ctr_q[bp.ex_idx]   <= ctr_d;
            if (w_alloc)  valid_q[bp.ex_idx] <= 1'b1;
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_alloc)  tag_q[bp.ex_idx]    <= w_ex_tag;
        if (w_wr_tgt) target_q[bp.ex_idx] <= bp.ex_target;
    end

endmodule
`default_nettype wire

// File: tb/tb_bht_btb_predictor.sv
`default_nettype none
// ============================================================================
// tb_bht_btb_predictor : bimodal and gshare instances against a table model
// Rev 1.0
// ============================================================================
module tb_bht_btb_predictor;
    localparam int AW = 32;
    localparam int N  = 64;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    bht_btb_predictor_if #(.ADDR_SIZE(AW), .IDX(IW)) bus0 ();
    bht_btb_predictor_if #(.ADDR_SIZE(AW), .IDX(IW)) bus1 ();

    bht_btb_predictor #(.MODE(0)) dut0 (.clk(clk), .reset(reset), .bp(bus0));
    bht_btb_predictor #(.MODE(1)) dut1 (.clk(clk), .reset(reset), .bp(bus1));

    always #5 clk = ~clk;

    // Reference model: per-entry state held as plain integers.
    bit          mv   [2][N];
    int          mtag [2][N];
    int          mctr [2][N];
    logic [31:0] mtgt [2][N];
    int          mghr [2];

    function automatic int midx(input int m, input logic [31:0] pc);
        int b;
        b = int'(pc >> 2) % 64;
        if (m == 1) b = b ^ (mghr[1] % 64);
        return b;
    endfunction

    function automatic int mtagf(input logic [31:0] pc);
        return int'(pc >> 8) % 256;
    endfunction

    function automatic logic [38:0] mpred(input int m, input logic [31:0] pc);
        int   i;
        logic t;
        i = midx(m, pc);
        t = mv[m][i] && (mtag[m][i] == mtagf(pc)) && (mctr[m][i] >= 2);
        return {t, (t ? mtgt[m][i] : pc + 32'd4), 6'(i)};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) begin
                mv[m][i]   = 1'b0;
                mctr[m][i] = 1;
            end
            mghr[m] = 0;
        end
    endtask

    task automatic model_flush();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < N; i++) mv[m][i] = 1'b0;
    endtask

    task automatic model_update(input int m, input logic [31:0] pc, input int i,
                                input bit jump, input bit taken, input logic [31:0] tgt);
        bit hit;
        hit = mv[m][i] && (mtag[m][i] == mtagf(pc));
        if (hit) begin
            if (jump) begin
                mctr[m][i] = 3;
                mtgt[m][i] = tgt;
            end else begin
                mctr[m][i] = taken ? ((mctr[m][i] < 3) ? mctr[m][i] + 1 : 3)
                                   : ((mctr[m][i] > 0) ? mctr[m][i] - 1 : 0);
                if (taken) mtgt[m][i] = tgt;
            end
        end else if (taken) begin
            mv[m][i]   = 1'b1;
            mtag[m][i] = mtagf(pc);
            mtgt[m][i] = tgt;
            mctr[m][i] = jump ? 3 : 2;
        end
        if (m == 1 && !jump) mghr[1] = ((mghr[1] << 1) | int'(taken)) % 64;
    endtask

    task automatic set_lookup(input logic [31:0] pc);
        bus0.if_pc = pc; bus0.if_pcplus4 = pc + 32'd4;
        bus1.if_pc = pc; bus1.if_pcplus4 = pc + 32'd4;
    endtask

    task automatic set_update(input logic [31:0] pc, input bit jump, input bit taken,
                              input logic [31:0] tgt, input bit flush);
        bus0.ex_pc = pc; bus0.ex_is_jump = jump; bus0.ex_taken = taken; bus0.ex_target = tgt;
        bus1.ex_pc = pc; bus1.ex_is_jump = jump; bus1.ex_taken = taken; bus1.ex_target = tgt;
        bus0.ex_idx = 6'(midx(0, pc));
        bus1.ex_idx = 6'(midx(1, pc));
        bus0.ex_valid = 1'b1; bus1.ex_valid = 1'b1;
        bus0.flush_tbl = flush; bus1.flush_tbl = flush;
    endtask

    task automatic clear_update();
        bus0.ex_valid = 1'b0; bus1.ex_valid = 1'b0;
        bus0.flush_tbl = 1'b0; bus1.flush_tbl = 1'b0;
    endtask

    task automatic drive_lookup(input logic [31:0] pc);
        @(negedge clk);
        set_lookup(pc);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input bit jump, input bit taken,
                             input logic [31:0] tgt, input bit flush);
        int i0, i1;
        @(negedge clk);
        i0 = midx(0, pc);
        i1 = midx(1, pc);
        set_update(pc, jump, taken, tgt, flush);
        @(posedge clk);
        if (flush) model_flush();
        else begin
            model_update(0, pc, i0, jump, taken, tgt);
            model_update(1, pc, i1, jump, taken, tgt);
        end
        #1 clear_update();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [38:0] obs;
        drive_lookup(32'h100);
        for (int m = 0; m < 2; m++) begin
            obs = (m == 0) ? {bus0.pred_taken, bus0.pred_target, bus0.pred_idx}
                           : {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
            tests++;
            if (obs !== {1'b0, 32'h104, 6'd0}) begin
                failed++;
                $display("FAIL reset_lookup dut%0d got %h want %h", m, obs, {1'b0, 32'h104, 6'd0});
            end
        end
    endtask

    task automatic test_alloc_train();
        logic [38:0] obs, exp1;
        do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        drive_lookup(32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b1, 32'h80, 6'd0}) begin
            failed++; $display("FAIL alloc_taken got %h want %h", obs, {1'b1, 32'h80, 6'd0});
        end
        exp1 = mpred(1, 32'h100);
        obs  = {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
        tests++;
        if (obs !== exp1) begin failed++; $display("FAIL alloc_gshare got %h want %h", obs, exp1); end
        repeat (2) do_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        drive_lookup(32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b0, 32'h104, 6'd0}) begin
            failed++; $display("FAIL train_nt got %h want %h", obs, {1'b0, 32'h104, 6'd0});
        end
    endtask

    task automatic test_alias();
        logic [38:0] obs;
        repeat (2) do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        drive_lookup(32'h200);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b0, 32'h204, 6'd0}) begin
            failed++; $display("FAIL alias_miss got %h want %h", obs, {1'b0, 32'h204, 6'd0});
        end
        drive_lookup(32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b1, 32'h80, 6'd0}) begin
            failed++; $display("FAIL alias_owner got %h want %h", obs, {1'b1, 32'h80, 6'd0});
        end
    endtask

    task automatic test_saturation();
        logic [38:0] obs;
        repeat (5) do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        do_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        drive_lookup(32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b1, 32'h80, 6'd0}) begin
            failed++; $display("FAIL sat_high got %h want %h", obs, {1'b1, 32'h80, 6'd0});
        end
        repeat (5) do_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        drive_lookup(32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b0, 32'h104, 6'd0}) begin
            failed++; $display("FAIL sat_low got %h want %h", obs, {1'b0, 32'h104, 6'd0});
        end
    endtask

    task automatic test_same_cycle();
        logic [38:0] obs, exp;
        int i0, i1;
        @(negedge clk);
        set_lookup(32'h3F0);
        i0 = midx(0, 32'h3F0);
        i1 = midx(1, 32'h3F0);
        set_update(32'h3F0, 1'b0, 1'b1, 32'hDEAD_BEE0, 1'b0);
        #1;
        for (int m = 0; m < 2; m++) begin
            exp = mpred(m, 32'h3F0);
            obs = (m == 0) ? {bus0.pred_taken, bus0.pred_target, bus0.pred_idx}
                           : {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
            tests++;
            if (obs !== exp) begin failed++; $display("FAIL same_cycle_pre dut%0d got %h want %h", m, obs, exp); end
        end
        @(posedge clk);
        model_update(0, 32'h3F0, i0, 1'b0, 1'b1, 32'hDEAD_BEE0);
        model_update(1, 32'h3F0, i1, 1'b0, 1'b1, 32'hDEAD_BEE0);
        #1 clear_update();
        #1;
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== {1'b1, 32'hDEAD_BEE0, 6'd60}) begin
            failed++; $display("FAIL same_cycle_post got %h want %h", obs, {1'b1, 32'hDEAD_BEE0, 6'd60});
        end
    endtask

    task automatic test_gshare();
        logic [38:0] obs, exp0;
        apply_reset();
        do_update(32'h300, 1'b0, 1'b1, 32'h1000, 1'b0);
        do_update(32'h400, 1'b0, 1'b1, 32'h2000, 1'b0);
        do_update(32'h500, 1'b0, 1'b0, 32'h3000, 1'b0);
        drive_lookup(32'h100);
        obs = {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
        tests++;
        if (obs !== {1'b0, 32'h104, 6'h06}) begin
            failed++; $display("FAIL gshare_idx got %h want %h", obs, {1'b0, 32'h104, 6'h06});
        end
        exp0 = mpred(0, 32'h100);
        obs  = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== exp0) begin failed++; $display("FAIL gshare_bimodal_side got %h want %h", obs, exp0); end
        do_update(32'h600, 1'b1, 1'b1, 32'h4000, 1'b0);
        drive_lookup(32'h100);
        obs = {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
        tests++;
        if (obs !== {1'b0, 32'h104, 6'h06}) begin
            failed++; $display("FAIL jump_no_shift got %h want %h", obs, {1'b0, 32'h104, 6'h06});
        end
    endtask

    task automatic test_flush();
        logic [38:0] obs, exp;
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h3F0;
        repeat (2) do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        do_update(32'h200, 1'b0, 1'b1, 32'h90, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_lookup(pcs[k]);
            for (int m = 0; m < 2; m++) begin
                exp = mpred(m, pcs[k]);
                obs = (m == 0) ? {bus0.pred_taken, bus0.pred_target, bus0.pred_idx}
                               : {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
                tests++;
                if (obs !== exp || obs[38] !== 1'b0) begin
                    failed++; $display("FAIL flush dut%0d pc=%h got %h want %h", m, pcs[k], obs, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [38:0] obs, exp;
        logic [31:0] pc, lpc;
        int r;
        for (int it = 0; it < 400; it++) begin
            pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2)
                | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 39);
            if (r == 0)       do_update(pc, 1'b0, 1'b1, $urandom, 1'b1);
            else if (r < 24)  do_update(pc, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
            else if (r < 30)  do_update(pc, 1'b1, 1'b1, $urandom, 1'b0);
            lpc = ($urandom_range(0, 1) == 1) ? pc
                : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2));
            drive_lookup(lpc);
            for (int m = 0; m < 2; m++) begin
                exp = mpred(m, lpc);
                obs = (m == 0) ? {bus0.pred_taken, bus0.pred_target, bus0.pred_idx}
                               : {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
                tests++;
                if (obs !== exp) begin
                    failed++; $display("FAIL random it=%0d dut%0d pc=%h got %h want %h", it, m, lpc, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_update();
        logic [38:0] obs, exp;
        repeat (2) do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        drive_lookup(32'h100);
        exp = mpred(0, 32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== exp) begin failed++; $display("FAIL pre_reset_hit got %h want %h", obs, exp); end
        @(negedge clk);
        set_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1 clear_update();
        for (int m = 0; m < 2; m++) begin
            obs = (m == 0) ? {bus0.pred_taken, bus0.pred_target, bus0.pred_idx}
                           : {bus1.pred_taken, bus1.pred_target, bus1.pred_idx};
            tests++;
            if (obs !== {1'b0, 32'h104, 6'd0}) begin
                failed++; $display("FAIL reset_mid dut%0d got %h want %h", m, obs, {1'b0, 32'h104, 6'd0});
            end
        end
        @(negedge clk);
        reset = 1'b1;
        // One taken then one not-taken leaves a weak-NT-initialised slot predicting not taken.
        do_update(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        do_update(32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
        drive_lookup(32'h100);
        exp = mpred(0, 32'h100);
        obs = {bus0.pred_taken, bus0.pred_target, bus0.pred_idx};
        tests++;
        if (obs !== exp) begin failed++; $display("FAIL post_reset_train got %h want %h", obs, exp); end
    endtask

    initial begin
        reset = 1'b0;
        set_lookup(32'h0);
        bus0.ex_pc = '0; bus0.ex_idx = '0; bus0.ex_is_jump = 1'b0; bus0.ex_taken = 1'b0;
        bus0.ex_target = '0;
        bus1.ex_pc = '0; bus1.ex_idx = '0; bus1.ex_is_jump = 1'b0; bus1.ex_taken = 1'b0;
        bus1.ex_target = '0;
        clear_update();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        test_reset();
        test_alloc_train();
        test_alias();
        test_saturation();
        test_same_cycle();
        test_gshare();
        test_flush();
        test_random();
        test_reset_mid_update();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not finish, got no end want end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
